ng_sw_cond: RTL and testbench

Switch conditioner for the front-panel and keypad switch inputs (MCLK, NSTEP, NRUN, INST, FCLK and similar) before they reach the clock/time-pulse generator and the control logic.
- Synchronises raw asynchronous contacts into the CLK_256K domain.
- Generates its own debounce sample tick from CLK_256K.
- Filters bounce by requiring N consecutive identical samples.
- Delivers clean levels plus single-cycle edge strobes.

---
 rtl/ng_sw_cond.sv | 120 ++++++++++++
 tb/tb_ng_sw_cond.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ng_sw_cond.sv
// ng_sw_cond: front-panel switch synchroniser, debounce filter and edge strobes.
// Define SWC_AUTOREPEAT_EN to add auto-repeat pulses on SW_FALL for REP_MASK channels.
module ng_sw_cond #(
  parameter int NSW = 8,
  parameter int DIV_W = 11,
  parameter int STABLE_CNT = 3,
  parameter logic [NSW-1:0] RST_LEVEL = {NSW{1'b1}},
  parameter logic [NSW-1:0] REP_MASK = {NSW{1'b0}},
  parameter int REP_DELAY = 64,
  parameter int REP_RATE = 8
) (
  input  logic           CLK_256K,
  input  logic           NPURST,
  input  logic [NSW-1:0] SW_IN,
  output logic [NSW-1:0] SW_OUT,
  output logic [NSW-1:0] SW_RISE,
  output logic [NSW-1:0] SW_FALL,
  output logic           TICK
);

  localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);

  logic [DIV_W-1:0] div;
  logic [NSW-1:0]   sync1;
  logic [NSW-1:0]   sync2;
  logic [3:0]       cnt [NSW];
  logic [3:0]       cnt_nxt [NSW];
  logic [NSW-1:0]   out_nxt;
  logic [NSW-1:0]   rise_nxt;
  logic [NSW-1:0]   fall_nxt;

`ifdef SWC_AUTOREPEAT_EN
  localparam logic [6:0] REP_LAST = 7'(REP_DELAY - 1);
  localparam logic [6:0] REP_RELOAD = 7'(REP_DELAY - REP_RATE);

  logic [6:0] hold [NSW];
  logic [6:0] hold_nxt [NSW];
`else
  logic unused_rep;
  assign unused_rep = ^{REP_MASK, 7'(REP_DELAY), 7'(REP_RATE)};
`endif

  always_comb begin
    out_nxt  = SW_OUT;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < NSW; i++) begin
      cnt_nxt[i] = cnt[i];
    end
    if (TICK) begin
      for (int i = 0; i < NSW; i++) begin
        if (sync2[i] == SW_OUT[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          out_nxt[i]  = sync2[i];
          cnt_nxt[i]  = '0;
          rise_nxt[i] = sync2[i];
          fall_nxt[i] = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
`ifdef SWC_AUTOREPEAT_EN
    for (int i = 0; i < NSW; i++) begin
      hold_nxt[i] = hold[i];
      if (!REP_MASK[i]) begin
        hold_nxt[i] = '0;
      end else if (SW_OUT[i] || out_nxt[i]) begin
        // idle, being pressed, or release accepted this tick
        hold_nxt[i] = '0;
      end else if (TICK) begin
        if (hold[i] == REP_LAST) begin
          hold_nxt[i] = REP_RELOAD;
          fall_nxt[i] = 1'b1;
        end else begin
          hold_nxt[i] = hold[i] + 7'd1;
        end
      end
    end
`endif
  end

  always_ff @(posedge CLK_256K or negedge NPURST) begin
    if (!NPURST) begin
      div     <= '0;
      TICK    <= 1'b0;
      sync1   <= RST_LEVEL;
      sync2   <= RST_LEVEL;
      SW_OUT  <= RST_LEVEL;
      SW_RISE <= '0;
      SW_FALL <= '0;
      for (int i = 0; i < NSW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      div     <= div + 1'b1;
      TICK    <= &div;
      sync1   <= SW_IN;
      sync2   <= sync1;
      SW_OUT  <= out_nxt;
      SW_RISE <= rise_nxt;
      SW_FALL <= fall_nxt;
      cnt     <= cnt_nxt;
    end
  end

`ifdef SWC_AUTOREPEAT_EN
  always_ff @(posedge CLK_256K or negedge NPURST) begin
    if (!NPURST) begin
      for (int i = 0; i < NSW; i++) begin
        hold[i] <= '0;
      end
    end else begin
      hold <= hold_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ng_sw_cond.sv
// tb_ng_sw_cond: scoreboard bench for ng_sw_cond (NSW=4, DIV_W=4, STABLE_CNT=3).
// Events (SW_OUT change or any strobe) are predicted per cycle and popped by a monitor.
module tb_ng_sw_cond;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_in = 4'hF;
  logic [3:0] sw_out;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       tick;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic mon_en = 1'b0;
  logic [3:0] prev_out = 4'hF;

  typedef struct {
    int         cyc;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_e;

  ng_sw_cond #(
    .NSW(4),
    .DIV_W(4),
    .STABLE_CNT(3)
`ifdef SWC_AUTOREPEAT_EN
    , .REP_MASK(4'b0001)
    , .REP_DELAY(4)
    , .REP_RATE(2)
`endif
  ) dut (
    .CLK_256K(clk),
    .NPURST(rst_n),
    .SW_IN(sw_in),
    .SW_OUT(sw_out),
    .SW_RISE(sw_rise),
    .SW_FALL(sw_fall),
    .TICK(tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      checks++;
      if (tick !== ((cyc != 0) && (cyc % 16 == 0))) begin
        errors++;
        $display("FAIL tick cyc=%0d: TICK=%b required %b",
                 cyc, tick, ((cyc != 0) && (cyc % 16 == 0)));
      end
      if (sw_out !== prev_out || sw_rise !== 4'h0 || sw_fall !== 4'h0) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected event cyc=%0d: out=%h rise=%h fall=%h, required none",
                   cyc, sw_out, sw_rise, sw_fall);
        end else begin
          mon_e = sbq.pop_front();
          if (cyc !== mon_e.cyc || sw_out !== mon_e.out ||
              sw_rise !== mon_e.rise || sw_fall !== mon_e.fall) begin
            errors++;
            $display("FAIL event: cyc=%0d out=%h rise=%h fall=%h, required cyc=%0d out=%h rise=%h fall=%h",
                     cyc, sw_out, sw_rise, sw_fall,
                     mon_e.cyc, mon_e.out, mon_e.rise, mon_e.fall);
          end
        end
      end
      prev_out = sw_out;
    end
  end

  function automatic int first_tick(input int d);
    int t;
    t = ((d + 2 + 15) / 16) * 16;
    if (t == 0) t = 16;
    return t;
  endfunction

  task automatic push_ev(input int c, input logic [3:0] o,
                         input logic [3:0] r, input logic [3:0] f);
    ev_t e;
    e.cyc = c;
    e.out = o;
    e.rise = r;
    e.fall = f;
    sbq.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    for (int k = 0; k < 4000 && cyc != n; k++) @(negedge clk);
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: cyc=%0d required %0d", cyc, n);
    end
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d pending events, required 0", name, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_reset;
    int first;
    int nt;
    rst_n = 1'b0;
    sw_in = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if ({sw_out, sw_rise, sw_fall, tick} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: out=%h rise=%h fall=%h tick=%b, required F 0 0 0",
               sw_out, sw_rise, sw_fall, tick);
    end
    prev_out = 4'hF;
    rst_n = 1'b1;
    mon_en = 1'b1;
    first = -1;
    nt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tick) begin
        if (first < 0) first = cyc;
        nt++;
      end
      checks++;
      if (sw_out !== 4'hF || sw_rise !== 4'h0 || sw_fall !== 4'h0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: out=%h rise=%h fall=%h, required F 0 0",
                 cyc, sw_out, sw_rise, sw_fall);
      end
    end
    checks++;
    if (first !== 16) begin
      errors++;
      $display("FAIL first_tick: cyc=%0d required 16", first);
    end
    checks++;
    if (nt !== 3) begin
      errors++;
      $display("FAIL tick_count: %0d required 3", nt);
    end
  endtask

  task automatic test_press;
    int v;
    wait_cyc(68);
    sw_in[0] = 1'b0;
    v = first_tick(68) + 33;
    push_ev(v, 4'hE, 4'h0, 4'h1);
    wait_cyc(v - 1);
    checks++;
    if (sw_out !== 4'hF) begin
      errors++;
      $display("FAIL press_early: out=%h required F", sw_out);
    end
    wait_cyc(v);
    checks++;
    if (sw_out !== 4'hE || sw_fall !== 4'h1) begin
      errors++;
      $display("FAIL press_accept: out=%h fall=%h, required E 1", sw_out, sw_fall);
    end
    wait_cyc(v + 2);
    checks++;
    if (sw_fall !== 4'h0) begin
      errors++;
      $display("FAIL press_clear: fall=%h required 0", sw_fall);
    end
    drain_check("press_drain");
  endtask

  task automatic test_bounce;
    int v;
    wait_cyc(132);
    sw_in[1] = 1'b0;
    wait_cyc(164);
    sw_in[1] = 1'b1;
    wait_cyc(180);
    sw_in[1] = 1'b0;
    v = first_tick(180) + 33;
    push_ev(v, 4'hC, 4'h0, 4'h2);
    wait_cyc(v - 1);
    checks++;
    if (sw_out !== 4'hE) begin
      errors++;
      $display("FAIL bounce_early: out=%h required E", sw_out);
    end
    wait_cyc(v + 2);
    drain_check("bounce_drain");
  endtask

  task automatic test_simul;
    int v1;
    int d2;
    int v2;
    int d3;
    int v3;
    wait_cyc(244);
    sw_in[2] = 1'b0;
    v1 = first_tick(244) + 33;
    push_ev(v1, 4'h8, 4'h0, 4'h4);
    d2 = v1 + 3 + int'($urandom_range(0, 15));
    wait_cyc(d2);
    sw_in = sw_in | 4'b0101;
    v2 = first_tick(d2) + 33;
    push_ev(v2, 4'hD, 4'h5, 4'h0);
    wait_cyc(v2);
    checks++;
    if (sw_out !== 4'hD || sw_rise !== 4'h5) begin
      errors++;
      $display("FAIL simul_rise: out=%h rise=%h, required D 5", sw_out, sw_rise);
    end
    d3 = v2 + 3;
    wait_cyc(d3);
    sw_in[1] = 1'b1;
    v3 = first_tick(d3) + 33;
    push_ev(v3, 4'hF, 4'h2, 4'h0);
    wait_cyc(v3 + 2);
    drain_check("simul_drain");
  endtask

  task automatic test_reset_mid;
    int d;
    int v;
    d = ((cyc / 16) + 1) * 16 + 4;
    wait_cyc(d);
    sw_in[3] = 1'b0;
    wait_cyc(first_tick(d) + 20);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_out, sw_rise, sw_fall, tick} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL mid_reset: out=%h rise=%h fall=%h tick=%b, required F 0 0 0",
                 sw_out, sw_rise, sw_fall, tick);
      end
    end
    rst_n = 1'b1;
    v = first_tick(0) + 33;
    push_ev(v, 4'h7, 4'h0, 4'h8);
    wait_cyc(v - 9);
    checks++;
    if (sw_out !== 4'hF) begin
      errors++;
      $display("FAIL mid_refilter: out=%h required F", sw_out);
    end
    wait_cyc(v + 2);
    drain_check("mid_drain");
  endtask

`ifdef SWC_AUTOREPEAT_EN
  task automatic test_autorepeat;
    int d;
    int a;
    int r;
    d = ((cyc / 16) + 1) * 16 + 4;
    wait_cyc(d);
    sw_in[0] = 1'b0;
    a = first_tick(d) + 32;
    push_ev(a + 1, 4'h6, 4'h0, 4'h1);
    for (int k = 0; k < 4; k++) begin
      push_ev(a + 65 + 32 * k, 4'h6, 4'h0, 4'h1);
    end
    wait_cyc(a + 65);
    checks++;
    if (sw_fall !== 4'h1) begin
      errors++;
      $display("FAIL rep_first: fall=%h required 1", sw_fall);
    end
    wait_cyc(a + 132);
    sw_in[0] = 1'b1;
    r = first_tick(a + 132) + 32;
    push_ev(r + 1, 4'h7, 4'h1, 4'h0);
    wait_cyc(r + 100);
    drain_check("rep_drain");
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_simul();
    test_reset_mid();
`ifdef SWC_AUTOREPEAT_EN
    test_autorepeat();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
